// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register-field width, IF/ID sequencing states and load-use limits.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [2:0] {
    RUN,
    MEMWAIT,
    LUSTALL,
    FLUSH,
    HALT
  } ifid_ctrl_state_t;

  localparam int LU_BUBBLES_MAX = 3;

endpackage

// File: rtl/lu_detect.sv
// Load-use hazard compare: the load in ID/EX writes a register the IF/ID instruction reads.
module lu_detect
  import cpu_types_pkg::*;
(
  input  logic     memRead_ID_EX,
  input  regbits_t Rt_ID_EX,
  input  regbits_t Rs_IF_ID,
  input  regbits_t Rt_IF_ID,
  output logic     lu
);

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign lu = memRead_ID_EX && (Rt_ID_EX != '0) &&
              ((Rt_ID_EX == Rs_IF_ID) || (Rt_ID_EX == Rt_IF_ID));

endmodule

// File: rtl/if_id_ctrl.sv
// IF/ID and PC sequencing controller: load, hold, flush and bubble decisions per cycle.
// Optional IF_ID_CTRL_PERF_EN adds wrapping stall_cnt / flush_cnt outputs.
module if_id_ctrl
  import cpu_types_pkg::*;
#(
  parameter int LU_BUBBLES = 1
) (
  input  logic     CLK,
  input  logic     RST,
  input  logic     ihit,
  input  logic     dhit,
  input  logic     dmem_req,
  input  regbits_t Rs_IF_ID,
  input  regbits_t Rt_IF_ID,
  input  logic     memRead_ID_EX,
  input  regbits_t Rt_ID_EX,
  input  logic     redirect,
  input  logic     halt,
  output logic     pc_en,
  output logic     if_id_en,
  output logic     if_id_flush,
  output logic     id_ex_bubble,
  output logic     halted
`ifdef IF_ID_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam int LU_CLAMP = (LU_BUBBLES > LU_BUBBLES_MAX) ? LU_BUBBLES_MAX :
                            (LU_BUBBLES < 1) ? 1 : LU_BUBBLES;
  localparam logic [1:0] LU_LOAD = 2'(LU_CLAMP - 1);

  ifid_ctrl_state_t state, state_next;
  logic [1:0]       bub_cnt, bub_cnt_next;
  logic             lu;
  logic             mem_stall;

  lu_detect u_lu_detect (
    .memRead_ID_EX (memRead_ID_EX),
    .Rt_ID_EX      (Rt_ID_EX),
    .Rs_IF_ID      (Rs_IF_ID),
    .Rt_IF_ID      (Rt_IF_ID),
    .lu            (lu)
  );

  // Once waiting, only dhit releases the freeze; from RUN a pending access must also be present.
  assign mem_stall = (state == MEMWAIT) ? !dhit : (dmem_req && !dhit);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= RUN;
      bub_cnt <= '0;
    end else begin
      state   <= state_next;
      bub_cnt <= bub_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    bub_cnt_next = bub_cnt;
    case (state)
      RUN, MEMWAIT: begin
        if (halt) begin
          state_next = HALT;
        end else if (mem_stall) begin
          state_next = MEMWAIT;
        end else if (redirect) begin
          state_next = FLUSH;
        end else if (lu) begin
          bub_cnt_next = LU_LOAD;
          state_next   = (LU_CLAMP > 1) ? LUSTALL : RUN;
        end else begin
          state_next = RUN;
        end
      end
      LUSTALL: begin
        bub_cnt_next = bub_cnt - 2'd1;
        if (bub_cnt <= 2'd1) state_next = RUN;
      end
      FLUSH:   state_next = RUN;
      HALT:    state_next = HALT;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    halted       = 1'b0;
    if (!RST) begin
      case (state)
        RUN, MEMWAIT: begin
          if (!(halt || mem_stall)) begin
            if (redirect) begin
              pc_en        = 1'b1;
              if_id_flush  = 1'b1;
              id_ex_bubble = 1'b1;
            end else if (lu) begin
              id_ex_bubble = 1'b1;
            end else if (!ihit) begin
              if_id_flush = 1'b1;
            end else begin
              pc_en    = 1'b1;
              if_id_en = 1'b1;
            end
          end
        end
        LUSTALL: id_ex_bubble = 1'b1;
        // The word fetched down the wrong path is dropped; the PC still moves on a hit.
        FLUSH: begin
          if_id_flush = 1'b1;
          pc_en       = ihit;
        end
        HALT:    halted = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef IF_ID_CTRL_PERF_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (state != HALT && !pc_en) stall_cnt <= stall_cnt + 32'd1;
      if (state != FLUSH && state_next == FLUSH) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_ctrl.sv
// Bench for if_id_ctrl: directed vector table, then randomized traffic against an event-level model.
module tb_if_id_ctrl;

  localparam int LUB = 2;

  logic       CLK = 1'b0;
  logic       RST, ihit, dhit, dmem_req, memRead_ID_EX, redirect, halt;
  logic [4:0] Rs_IF_ID, Rt_IF_ID, Rt_ID_EX;
  logic       pc_en, if_id_en, if_id_flush, id_ex_bubble, halted;
`ifdef IF_ID_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  always #5 CLK = ~CLK;

  if_id_ctrl #(.LU_BUBBLES(LUB)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .ihit          (ihit),
    .dhit          (dhit),
    .dmem_req      (dmem_req),
    .Rs_IF_ID      (Rs_IF_ID),
    .Rt_IF_ID      (Rt_IF_ID),
    .memRead_ID_EX (memRead_ID_EX),
    .Rt_ID_EX      (Rt_ID_EX),
    .redirect      (redirect),
    .halt          (halt),
    .pc_en         (pc_en),
    .if_id_en      (if_id_en),
    .if_id_flush   (if_id_flush),
    .id_ex_bubble  (id_ex_bubble),
    .halted        (halted)
`ifdef IF_ID_CTRL_PERF_EN
    ,
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
`endif
  );

  // exp bits: {pc_en, if_id_en, if_id_flush, id_ex_bubble, halted}
  typedef struct {
    logic       rst, ihit, dhit, dreq, mr;
    logic [4:0] rt_ex, rs, rt;
    logic       redir, hlt;
    logic [4:0] exp;
  } vec_t;

  vec_t vq[$];
  int   errors = 0;
  int   checks = 0;

  // Model: cycles of stall still owed, a pending flush cycle, halted, waiting on memory.
  int          lu_left   = 0;
  bit          flush_pend = 0;
  bit          halt_m    = 0;
  bit          wait_m    = 0;
  int unsigned stall_m   = 0;
  int unsigned flush_m   = 0;

  function automatic vec_t mk(input logic rst, ihit, dhit, dreq, mr,
                              input logic [4:0] rt_ex, rs, rt,
                              input logic redir, hlt, input logic [4:0] exp);
    vec_t v;
    v.rst = rst; v.ihit = ihit; v.dhit = dhit; v.dreq = dreq; v.mr = mr;
    v.rt_ex = rt_ex; v.rs = rs; v.rt = rt; v.redir = redir; v.hlt = hlt; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  function automatic logic [4:0] model_step(input vec_t v);
    logic [4:0] e = '0;
    bit was_halted = halt_m;
    bit hazard = v.mr && (v.rt_ex != 0) && (v.rt_ex == v.rs || v.rt_ex == v.rt);
    if (v.rst) begin
      lu_left = 0; flush_pend = 0; halt_m = 0; wait_m = 0; stall_m = 0; flush_m = 0;
      return e;
    end
    if (halt_m) e[0] = 1'b1;
    else if (lu_left > 0) begin
      e[1] = 1'b1;
      lu_left--;
    end else if (flush_pend) begin
      e[2] = 1'b1;
      e[4] = v.ihit;
      flush_pend = 0;
    end else if (v.hlt) begin
      halt_m = 1;
      wait_m = 0;
    end else if (wait_m ? !v.dhit : (v.dreq && !v.dhit)) begin
      wait_m = 1;
    end else begin
      wait_m = 0;
      if (v.redir) begin
        e[4] = 1'b1; e[2] = 1'b1; e[1] = 1'b1;
        flush_pend = 1;
        flush_m++;
      end else if (hazard) begin
        e[1] = 1'b1;
        lu_left = LUB - 1;
      end else if (!v.ihit) e[2] = 1'b1;
      else begin
        e[4] = 1'b1; e[3] = 1'b1;
      end
    end
    if (!was_halted && !e[4]) stall_m++;
    return e;
  endfunction

  task automatic apply(input vec_t v, input bit use_tab, input string tag);
    logic [4:0] got, em;
    RST = v.rst; ihit = v.ihit; dhit = v.dhit; dmem_req = v.dreq;
    memRead_ID_EX = v.mr; Rt_ID_EX = v.rt_ex; Rs_IF_ID = v.rs; Rt_IF_ID = v.rt;
    redirect = v.redir; halt = v.hlt;
    @(negedge CLK);
    got = {pc_en, if_id_en, if_id_flush, id_ex_bubble, halted};
`ifdef IF_ID_CTRL_PERF_EN
    if (!v.rst) begin
      chk({tag, " stall_cnt"}, stall_cnt, stall_m);
      chk({tag, " flush_cnt"}, flush_cnt, flush_m);
    end
`endif
    em = model_step(v);
    if (use_tab) chk({tag, " table outs"}, {27'd0, got}, {27'd0, v.exp});
    chk({tag, " model outs"}, {27'd0, got}, {27'd0, em});
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; ihit = 0; dhit = 0; dmem_req = 0; memRead_ID_EX = 0;
    Rt_ID_EX = 0; Rs_IF_ID = 0; Rt_IF_ID = 0; redirect = 0; halt = 0;

    //           rst ihit dhit dreq mr rt_ex rs rt redir hlt  exp
    vq.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000));
    vq.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000));
    vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000));
    vq.push_back(mk(0, 1, 0, 0, 1, 5, 5, 0, 0, 0, 5'b00010));
    vq.push_back(mk(0, 1, 0, 0, 0, 0, 5, 0, 0, 0, 5'b00010));
    vq.push_back(mk(0, 1, 0, 0, 0, 0, 5, 0, 0, 0, 5'b11000));
    vq.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 5'b11000));
    vq.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 5'b00000));
    vq.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 5'b00000));
    vq.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 5'b00000));
    vq.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 5'b11000));
    vq.push_back(mk(0, 1, 0, 0, 1, 7, 0, 7, 1, 0, 5'b10110));
    vq.push_back(mk(0, 1, 0, 0, 1, 7, 0, 7, 0, 0, 5'b10100));
    vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00100));
    vq.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 5'b00000));
    vq.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 5'b00000));
    for (int i = 0; i < 10; i++)
      vq.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 5'b00001));
    vq.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000));
    vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000));
    vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 5'b10110));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00100));
    vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000));

    @(posedge CLK);
    #1;
    for (int i = 0; i < vq.size(); i++)
      apply(vq[i], 1'b1, $sformatf("vec%0d", i));

    apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000), 1'b1, "rand_rst");
    for (int i = 0; i < 800; i++) begin
      vec_t v;
      v.rst   = ($urandom_range(0, 59) == 0);
      v.ihit  = ($urandom_range(0, 3) != 0);
      v.dhit  = $urandom_range(0, 1) == 1;
      v.dreq  = ($urandom_range(0, 2) == 0);
      v.mr    = $urandom_range(0, 1) == 1;
      v.rt_ex = 5'($urandom_range(0, 3));
      v.rs    = 5'($urandom_range(0, 3));
      v.rt    = 5'($urandom_range(0, 3));
      v.redir = ($urandom_range(0, 5) == 0);
      v.hlt   = ($urandom_range(0, 49) == 0);
      v.exp   = '0;
      apply(v, 1'b0, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
